// File: rtl/cache_mem_arbiter.sv
// Purpose: shares one pmem port between I-cache and D-cache, one line transfer at a time (ARB_ROUND_ROBIN_EN: alternate on ties).
// Latency: grant on the edge a request is seen, strobe the cycle after, resp combinational with pmem_resp.
// Backpressure: a requester holds its level request until its resp pulse; the loser waits through one IDLE cycle.
module cache_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t state, state_nxt;
    logic   op_write_q;
    logic   d_req;
    logic   grant_i;
    logic   grant_d;

    // A simultaneous read and write from the D-cache is a write-back first.
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_d <= 1'b1;
        end else if (grant_d) begin
            last_grant_d <= 1'b1;
        end else if (grant_i) begin
            last_grant_d <= 1'b0;
        end
    end

    assign grant_d = (state == IDLE) && d_req && (!i_read || !last_grant_d);
`else
    assign grant_d = (state == IDLE) && d_req;
`endif

    assign grant_i = (state == IDLE) && i_read && !grant_d;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = SERVE_D;
                end else if (grant_i) begin
                    state_nxt = SERVE_I;
                end
            end
            SERVE_I: if (pmem_resp) state_nxt = IDLE;
            SERVE_D: if (pmem_resp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latched copies drive pmem so requesters may change their inputs mid-transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_addr  <= '0;
            pmem_wdata <= '0;
            op_write_q <= 1'b0;
        end else if (grant_d) begin
            pmem_addr  <= d_addr;
            pmem_wdata <= d_wdata;
            op_write_q <= d_write;
        end else if (grant_i) begin
            pmem_addr  <= i_addr;
            op_write_q <= 1'b0;
        end
    end

    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state)
            SERVE_I: begin
                pmem_read = 1'b1;
                i_resp    = pmem_resp;
            end
            SERVE_D: begin
                pmem_write = op_write_q;
                pmem_read  = ~op_write_q;
                d_resp     = pmem_resp;
            end
            default: ;
        endcase
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule
